booth_mult_seq: RTL
===================

# booth_mult_seq

Sequential radix-4 Booth multiplier with integrated controller, the parametrised successor to the fixed 8x8 multiplier datapath. It accepts two WIDTH-bit operands on a start pulse, retires one Booth digit per cycle, and returns the exact 2*WIDTH-bit product with a done pulse. It supports signed and unsigned operands selected per operation, and sits as a multi-cycle execution unit beside the ALU.

## Interface
- WIDTH, 8, operand width; must be even and >= 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sgn  input  1  1 = both operands two's complement, 0 = both unsigned; captured with start.
- a_in  input  WIDTH  multiplicand; captured with start.
- b_in  input  WIDTH  multiplier; captured with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; p_out valid.
- p_out  output  2*WIDTH  product; holds until the next completion or reset.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the digit counter reaches ITER-1, or on early termination (see Configuration).
  - DONE -> RUN if start, else IDLE.
- ITER = WIDTH/2 when sgn=1. ITER = WIDTH/2+1 when sgn=0; the multiplier is zero-extended by 2 bits so the top digit is non-negative.
- Capture on start:
  - Multiplicand is sign- or zero-extended to WIDTH+2 bits per sgn.
  - Accumulator is cleared.
  - Multiplier is loaded with implicit bit x[-1]=0.
  - Counter is set to 0.
- Each RUN cycle:
  - Recode the current triplet {x[2i+1], x[2i], x[2i-1]} to a digit in {-2,-1,0,+1,+2}.
  - Add to or subtract from the accumulator: 0, ±A, or ±2A. Negation is done by inverting and adding 1 at the LSB.
  - Arithmetic right shift of {acc, multiplier} by 2.
  - Counter increments.
- Internal widths:
  - Accumulator is WIDTH+2 bits, so ±2A never overflows.
  - Sign fill on the shift is the accumulator MSB in both modes. The accumulator is signed even in unsigned mode.
- On entry to DONE, p_out <= low 2*WIDTH bits of the final {acc, multiplier} (unsigned mode drops the 2 extension bits). The result equals a_in*b_in exactly.
- start while busy=1 is ignored: no capture, no effect on the current operation.
- Operand inputs are don't-care except on the start cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, p_out 0, internal registers 0.
- Asserting reset at any time aborts the operation immediately. busy, done and p_out go to 0, and no done is issued for the aborted operation.
- Start sampled at edge k:
  - busy=1 from k to k+ITER.
  - done=1 for exactly the cycle after edge k+ITER.
  - p_out is updated at that same edge.
  - Latency from start edge to done high is ITER+1 edges: 5 for WIDTH=8 signed, 6 for WIDTH=8 unsigned.
- Back-to-back: start during the DONE cycle is accepted. busy rises on the next edge with no idle bubble, and p_out keeps the previous result until the new completion.
- done and busy are never high together.

## Configuration
- BOOTH_EARLY_TERM_EN defined: in RUN, if the unconsumed multiplier bits plus the current x[-1] are all 0 or all 1, every remaining digit is 0.
  - The FSM jumps to DONE on that edge.
  - The product is formed by an arithmetic right shift of {acc, multiplier} by 2*(remaining digits).
  - p_out is bit-identical to the full run; only latency shrinks.
  - Minimum latency is 2 edges.
- Undefined: always ITER RUN cycles. The shifter and detect logic are absent.

## Test plan
- WIDTH=8, sgn=1, a=0x80, b=0x80 (-128*-128) -> p_out=0x4000; done exactly 5 edges after start; busy high 4 cycles.
- WIDTH=8, sgn=0, a=0xFF, b=0xFF -> p_out=0xFE01 after 6 edges. Same operands with sgn=1 -> p_out=0x0001.
- start pulsed again 2 cycles into a run with a=3, b=5 -> ignored; first result 7*(-2): a=0x07, b=0xFE, sgn=1 -> p_out=0xFFF2. Then start in the DONE cycle with a=3, b=5 -> p_out=0x000F with no idle cycle between operations.
- Reset asserted in the 2nd RUN cycle -> busy, done, p_out=0 immediately; no done pulse after release; a following start (a=2, b=3) -> p_out=6.
- BOOTH_EARLY_TERM_EN, WIDTH=16, sgn=1, b=0x0001, a=0x8000 -> p_out=0xFFFF8000 with done 2 edges after start. Without the macro -> same value after 9 edges.
- WIDTH=16, 10k random operands in both sgn modes, compared against a reference model -> zero mismatches. Each done comes ITER+1 edges after its start (without the macro).

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one digit per RUN cycle, done pulses ITER+1 edges after start.
// start is ignored while busy; defining BOOTH_EARLY_TERM_EN ends a run once every remaining digit is zero.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p_out
);

  localparam int XW = WIDTH + 2;
  localparam int RW = 2 * XW;
  localparam int CW = $clog2(WIDTH / 2 + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [XW-1:0]      mcand, acc, mq;
  logic               xm1, sgn_q;
  logic [CW-1:0]      cnt, last_idx;
  logic [2:0]         trip;
  logic               neg, two, zero, last, finish, accept;
  logic [XW-1:0]      addend, acc_sum;
  logic [RW-1:0]      r_shift;
  logic [2*WIDTH-1:0] p_sel;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign last_idx = sgn_q ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
  assign last     = (cnt == last_idx);

  // Booth recode of {x[2i+1], x[2i], x[2i-1]}; negation is invert plus carry-in
  always_comb begin
    trip    = {mq[1], mq[0], xm1};
    zero    = (trip == 3'b000) || (trip == 3'b111);
    two     = (trip == 3'b011) || (trip == 3'b100);
    neg     = trip[2];
    addend  = zero ? '0 : (two ? {mcand[XW-2:0], 1'b0} : mcand);
    acc_sum = acc + (neg ? ~addend : addend) + {{(XW-1){1'b0}}, neg};
    r_shift = $signed({acc_sum, mq}) >>> 2;
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH:1] diff;
  logic           term;
  logic [CW-1:0]  rem;
  logic [RW-1:0]  r_fin;

  // unconsumed multiplier bits sit in mq[WIDTH+1-2*cnt:0]; uniform bits mean all-zero digits
  always_comb begin
    for (int j = 1; j <= WIDTH; j++)
      diff[j] = (mq[j] ^ mq[j+1]) && (j <= WIDTH - 2 * int'(cnt));
    term   = ~|diff;
    rem    = last_idx - cnt;
    r_fin  = $signed(r_shift) >>> {rem, 1'b0};
    finish = last || term;
    p_sel  = sgn_q ? r_fin[2*WIDTH+1:2] : r_fin[2*WIDTH-1:0];
  end
`else
  always_comb begin
    finish = last;
    p_sel  = sgn_q ? r_shift[2*WIDTH+1:2] : r_shift[2*WIDTH-1:0];
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      xm1   <= 1'b0;
      cnt   <= '0;
      sgn_q <= 1'b0;
      p_out <= '0;
    end else if (accept) begin
      mcand <= sgn ? {{2{a_in[WIDTH-1]}}, a_in} : {2'b00, a_in};
      mq    <= sgn ? {{2{b_in[WIDTH-1]}}, b_in} : {2'b00, b_in};
      acc   <= '0;
      xm1   <= 1'b0;
      cnt   <= '0;
      sgn_q <= sgn;
    end else if (state == RUN) begin
      {acc, mq} <= r_shift;
      xm1       <= mq[1];
      cnt       <= cnt + CW'(1);
      if (finish) p_out <= p_sel;
    end
  end

endmodule
